// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide controller.
//   md_op_t     - request opcode (MULT, MULTU, DIV, DIVU)
//   md_state_t  - controller FSM states
//   md_result_t - {hi, lo} result pair
package muldiv_pkg;

    localparam int DIV_ITERS_DEFAULT = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    // Two's-complement negate when c is set.
    function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
        return c ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter: restoring divider datapath, one shift-subtract step per cycle.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - load dividend/divisor magnitudes, clear remainder
//   dividend, divisor - unsigned magnitudes sampled on start
//   step              - perform one iteration this cycle
//   done              - this step is the last one (combinational)
//   quo_next/rem_next - quotient/remainder after this cycle's step
module div_iter #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        step,
    output logic        done,
    output logic [31:0] quo_next,
    output logic [31:0] rem_next
);
    localparam int CW = $clog2(ITERS);

    logic [32:0]   r_q;
    logic [31:0]   q_q;
    logic [31:0]   d_q;
    logic [CW-1:0] cnt_q;

    logic [32:0] shifted;
    logic [33:0] diff;
    logic [32:0] rem_full;
    logic        unused_r_msb;

    // Divisor magnitude can be 0x80000000, so the trial subtract is done
    // one bit wider than the shifted remainder to keep the borrow visible.
    always_comb begin
        shifted  = {r_q[31:0], q_q[31]};
        diff     = {1'b0, shifted} - {2'b00, d_q};
        rem_full = diff[33] ? shifted : diff[32:0];
        quo_next = {q_q[30:0], ~diff[33]};
        rem_next = rem_full[31:0];
    end

    // Remainder stays below the divisor, so its top bit is always clear.
    assign unused_r_msb = r_q[32];
    assign done         = step && (cnt_q == CW'(ITERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else if (start) begin
            r_q   <= '0;
            q_q   <= dividend;
            d_q   <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            r_q   <= rem_full;
            q_q   <= quo_next;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle HI/LO multiply/divide controller for the execute stage.
// Optional build macro: MULDIV_DIV_EARLY_EN - divides with |b|==0 or |a|<|b|
// finish straight from IDLE without iterating.
// Ports:
//   clk, resetn        - clock, asynchronous active-low reset
//   req_valid, req_op  - mul/div request and opcode (md_op_t encoding)
//   req_a, req_b       - rs / rt operands
//   e_fire             - execute stage advances this cycle
//   flush              - kill in-flight op
//   stall              - hold execute stage
//   res_valid, hi, lo  - result held until e_fire
//
// state | meaning
// IDLE  | waiting for a request; accepts and latches operands
// MUL   | multiplier latency countdown
// DIV   | restoring divider iterating
// DONE  | result valid, held until the stage advances
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT   = 2,
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        e_fire,
    input  logic        flush,
    output logic        stall,
    output logic        res_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    md_state_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    md_op_t      op_q;
    logic        sa_q, sb_q;
    logic [31:0] mag_a_q, mag_b_q;
    md_result_t  res_q, res_d;

    md_op_t      in_op;
    logic        in_signed, in_sa, in_sb, in_is_div;
    logic [31:0] in_mag_a, in_mag_b;
    logic        accept, early, load_res, neg_q;
    logic        div_start, div_step, div_done;
    logic [31:0] div_quo, div_rem;
    logic [63:0] prod;

    assign in_op     = md_op_t'(req_op);
    assign in_signed = (in_op == MD_MULT) || (in_op == MD_DIV);
    assign in_is_div = (in_op == MD_DIV) || (in_op == MD_DIVU);
    assign in_sa     = in_signed & req_a[31];
    assign in_sb     = in_signed & req_b[31];
    assign in_mag_a  = neg_if(in_sa, req_a);
    assign in_mag_b  = neg_if(in_sb, req_b);
    assign accept    = (state_q == IDLE) && req_valid && !flush;

`ifdef MULDIV_DIV_EARLY_EN
    assign early = in_is_div && ((in_mag_b == 32'd0) || (in_mag_a < in_mag_b));
`else
    assign early = 1'b0;
`endif

    assign div_start = accept && in_is_div && !early;
    assign div_step  = (state_q == DIV);

    div_iter #(.ITERS(DIV_ITERS)) u_div_iter (
        .clk      (clk),
        .rst_n    (resetn),
        .start    (div_start),
        .dividend (in_mag_a),
        .divisor  (in_mag_b),
        .step     (div_step),
        .done     (div_done),
        .quo_next (div_quo),
        .rem_next (div_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (early) begin
                        state_d = DONE;
                    end else if (in_is_div) begin
                        state_d = DIV;
                    end else begin
                        state_d = MUL;
                        cnt_d   = 4'(MUL_LAT - 1);
                    end
                end
            end
            MUL: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DIV: begin
                if (div_done) state_d = DONE;
            end
            DONE: begin
                if (e_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Result is formed only on the transition into DONE, from whichever
    // state is completing; sign flags are clear for unsigned ops.
    always_comb begin
        prod  = 64'(mag_a_q) * 64'(mag_b_q);
        neg_q = ((op_q == MD_MULT) || (op_q == MD_DIV)) && (sa_q ^ sb_q);
        res_d = res_q;
        case (state_q)
            MUL: begin
                res_d = neg_q ? (~prod + 64'd1) : prod;
            end
            DIV: begin
                res_d.lo = neg_if(neg_q, div_quo);
                res_d.hi = neg_if(sa_q, div_rem);
            end
`ifdef MULDIV_DIV_EARLY_EN
            IDLE: begin
                res_d.lo = neg_if(in_sa ^ in_sb, (in_mag_b == 32'd0) ? 32'hFFFF_FFFF : 32'd0);
                res_d.hi = neg_if(in_sa, in_mag_a);
            end
`endif
            default: ;
        endcase
    end

    assign load_res = (state_d == DONE) && (state_q != DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            mag_a_q <= '0;
            mag_b_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q    <= in_op;
                sa_q    <= in_sa;
                sb_q    <= in_sb;
                mag_a_q <= in_mag_a;
                mag_b_q <= in_mag_b;
            end
            if (load_res) res_q <= res_d;
        end
    end

    assign stall     = (((state_q == IDLE) && req_valid) || (state_q == MUL) || (state_q == DIV)) && !flush;
    assign res_valid = (state_q == DONE);
    assign hi        = res_q.hi;
    assign lo        = res_q.lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        e_fire = 1'b0;
    logic        flush = 1'b0;
    logic        stall, res_valid;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    md_result_t exp_q[$];
    md_result_t mon_e;
    logic prev_valid = 1'b0;

    localparam int MUL_STALL = 3;
    localparam int DIV_STALL = 33;
`ifdef MULDIV_DIV_EARLY_EN
    localparam int EARLY_STALL = 1;
`else
    localparam int EARLY_STALL = 33;
`endif

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(2), .DIV_ITERS(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .e_fire    (e_fire),
        .flush     (flush),
        .stall     (stall),
        .res_valid (res_valid),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each newly presented result against the scoreboard.
    always @(negedge clk) begin
        if (res_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: res_valid with nothing pending, hi=0x%0h lo=0x%0h", hi, lo);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, mon_e.hi});
                check("result_lo", {32'd0, lo}, {32'd0, mon_e.lo});
            end
        end
        prev_valid = res_valid;
    end

    // Called just after a rising edge; issues one op and retires it with e_fire.
    task automatic run_op(input string name, input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int exp_stall, input int hold);
        int n;
        int st;
        md_result_t e;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        e_fire    = 1'b0;
        e.hi = ehi;
        e.lo = elo;
        exp_q.push_back(e);
        n  = 0;
        st = 0;
        do begin
            @(negedge clk);
            if (!res_valid) begin
                if (stall) st++;
                n++;
            end
        end while (!res_valid && n <= 200);
        check({name, "_latency"}, 64'(n), 64'(exp_stall));
        check({name, "_stall_cycles"}, 64'(st), 64'(exp_stall));
        for (int k = 0; k < hold; k++) begin
            if (k > 0) @(negedge clk);
            check({name, "_hold_flags"}, {62'd0, res_valid, stall}, 64'd2);
            check({name, "_hold_hilo"}, {hi, lo}, {ehi, elo});
        end
        @(posedge clk); #1;
        e_fire = 1'b1;
        @(posedge clk); #1;
        e_fire    = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check({name, "_idle_after_fire"}, {62'd0, res_valid, stall}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2 resetn = 1'b0;
        #2;
        check("reset_stall", {63'd0, stall}, 64'd0);
        check("reset_valid", {63'd0, res_valid}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        @(posedge clk); #1;
        run_op("mult_neg3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_STALL, 1);
        @(posedge clk); #1;
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_STALL, 6);
        @(posedge clk); #1;
        run_op("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_STALL, 1);
        @(posedge clk); #1;
        run_op("div_min_neg1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_STALL, 1);
        @(posedge clk); #1;
        run_op("divu_5_0", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, EARLY_STALL, 1);
        @(posedge clk); #1;
        run_op("divu_3_9", MD_DIVU, 32'd3, 32'd9, 32'd3, 32'd0, EARLY_STALL, 1);
        @(posedge clk); #1;
        run_op("multu_small", MD_MULTU, 32'd6, 32'd9, 32'd0, 32'd54, MUL_STALL, 1);

        // Flush at divide iteration 10: stall drops that cycle, no result.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = MD_DIV;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {62'd0, res_valid, stall}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_STALL, 1);

        // Asynchronous reset at divide iteration 20.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = MD_DIVU;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        resetn    = 1'b0;
        req_valid = 1'b0;
        #2;
        check("midreset_stall", {63'd0, stall}, 64'd0);
        check("midreset_valid", {63'd0, res_valid}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        run_op("multu_after_reset", MD_MULTU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, MUL_STALL, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
